// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared state encoding and constants for the CDB arbiter
package cdb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } cdb_state_t;

  localparam int NO_GRANT   = 0;
  localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first request at or after ptr
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   u;

  // Walk the units starting at ptr and wrapping; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    u         = 0;
    for (int k = 0; k < N; k++) begin
      u = (int'(ptr) + k) % N;
      if (!found && req[u]) begin
        found     = 1'b1;
        grant[u]  = 1'b1;
        grant_idx = IW'(u);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter (optional per-unit grant counters via CDB_ARB_STATS_EN)
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int  NUM_UNITS   = 3,
  parameter int  XMIT_CYCLES = 1,
  localparam int IW          = $clog2(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] CDB_rts,
  output logic [NUM_UNITS-1:0] CDB_xmit,
  output logic [IW-1:0]        grant_id,
  output logic                 cdb_busy,
  output logic                 arb_error
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH*NUM_UNITS-1:0] grant_count
`endif
);

  cdb_state_t           state, state_d;
  logic [NUM_UNITS-1:0] xmit_d;
  logic [IW-1:0]        gid_d;
  logic                 busy_d, err_d;
  logic [IW-1:0]        rr_ptr, rr_ptr_d;
  logic [1:0]           cnt, cnt_d;
  logic [NUM_UNITS-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;

  rr_pick #(.N(NUM_UNITS), .IW(IW)) u_pick (
    .req       (CDB_rts),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // State and all outputs are registered; async reset clears the bus at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      CDB_xmit  <= '0;
      grant_id  <= IW'(NO_GRANT);
      cdb_busy  <= 1'b0;
      arb_error <= 1'b0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      CDB_xmit  <= xmit_d;
      grant_id  <= gid_d;
      cdb_busy  <= busy_d;
      arb_error <= err_d;
      rr_ptr    <= rr_ptr_d;
      cnt       <= cnt_d;
    end
  end

  // Next state: RELEASE doubles as the arbitration point so grants can be back to back.
  always_comb begin
    state_d  = state;
    xmit_d   = CDB_xmit;
    gid_d    = grant_id;
    busy_d   = cdb_busy;
    err_d    = 1'b0;
    rr_ptr_d = rr_ptr;
    cnt_d    = cnt;
    case (state)
      IDLE, RELEASE: begin
        state_d = IDLE;
        xmit_d  = '0;
        gid_d   = IW'(NO_GRANT);
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (|CDB_rts) begin
          state_d = GRANT;
          xmit_d  = pick_grant;
          gid_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = 2'(XMIT_CYCLES - 1);
        end
      end
      GRANT: begin
        if (((CDB_rts & CDB_xmit) == '0) || (cnt == 2'd0)) begin
          err_d    = ((CDB_rts & CDB_xmit) == '0);
          state_d  = RELEASE;
          xmit_d   = '0;
          gid_d    = IW'(NO_GRANT);
          busy_d   = 1'b0;
          cnt_d    = '0;
          rr_ptr_d = (grant_id == IW'(NUM_UNITS - 1)) ? '0 : grant_id + IW'(1);
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        xmit_d  = '0;
        gid_d   = IW'(NO_GRANT);
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef CDB_ARB_STATS_EN
  logic grant_evt;
  assign grant_evt = ((state == IDLE) || (state == RELEASE)) && (|CDB_rts);

  // Saturating per-unit grant counters, bumped on each entry to GRANT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_count <= '0;
    end else if (grant_evt) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (pick_grant[i] && (grant_count[STAT_WIDTH*i +: STAT_WIDTH] != {STAT_WIDTH{1'b1}})) begin
          grant_count[STAT_WIDTH*i +: STAT_WIDTH] <= grant_count[STAT_WIDTH*i +: STAT_WIDTH] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized and directed bench for cdb_arbiter against a timestamp model
module tb_cdb_arbiter;

  logic       clock;
  logic       reset_n;
  logic [2:0] rts;
  logic [2:0] xmit_a, xmit_b;
  logic [1:0] gid_a, gid_b;
  logic       busy_a, busy_b, err_a, err_b;
`ifdef CDB_ARB_STATS_EN
  logic [47:0] gc_a, gc_b;
`endif

  cdb_arbiter #(.NUM_UNITS(3), .XMIT_CYCLES(1)) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .CDB_rts   (rts),
    .CDB_xmit  (xmit_a),
    .grant_id  (gid_a),
    .cdb_busy  (busy_a),
    .arb_error (err_a)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_count (gc_a)
`endif
  );

  cdb_arbiter #(.NUM_UNITS(3), .XMIT_CYCLES(3)) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .CDB_rts   (rts),
    .CDB_xmit  (xmit_b),
    .grant_id  (gid_b),
    .cdb_busy  (busy_b),
    .arb_error (err_b)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_count (gc_b)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each instance remembers the edge index of its last grant,
  // the grantee, the earliest edge it may arbitrate again and its round-robin start.
  int ncyc;
  int ptr[2], gunit[2], gedge[2], free_at[2];
  bit active[2], err[2];

  function automatic int xc(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset(input int k);
    active[k]  = 0;
    err[k]     = 0;
    ptr[k]     = 0;
    gunit[k]   = 0;
    gedge[k]   = 0;
    free_at[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit found;
    err[k] = 0;
    if (!reset_n) begin
      model_reset(k);
    end else if (active[k]) begin
      if (!rts[gunit[k]] || (ncyc == gedge[k] + xc(k))) begin
        err[k]     = !rts[gunit[k]];
        active[k]  = 0;
        ptr[k]     = (gunit[k] + 1) % 3;
        free_at[k] = ncyc + 1;
      end
    end else if (ncyc >= free_at[k] && rts != 3'b000) begin
      found = 0;
      for (int j = 0; j < 3; j++) begin
        if (!found && rts[(ptr[k] + j) % 3]) begin
          found    = 1;
          gunit[k] = (ptr[k] + j) % 3;
        end
      end
      active[k] = 1;
      gedge[k]  = ncyc;
    end
  endtask

  task automatic compare_models();
    logic [2:0] ex;
    for (int k = 0; k < 2; k++) begin
      ex = active[k] ? (3'b001 << gunit[k]) : 3'b000;
      if (k == 0) begin
        check($sformatf("a.xmit@%0d", ncyc), 32'(xmit_a), 32'(ex));
        check($sformatf("a.gid@%0d", ncyc), 32'(gid_a), active[k] ? gunit[k] : 0);
        check($sformatf("a.busy@%0d", ncyc), 32'(busy_a), 32'(active[k]));
        check($sformatf("a.err@%0d", ncyc), 32'(err_a), 32'(err[k]));
      end else begin
        check($sformatf("b.xmit@%0d", ncyc), 32'(xmit_b), 32'(ex));
        check($sformatf("b.gid@%0d", ncyc), 32'(gid_b), active[k] ? gunit[k] : 0);
        check($sformatf("b.busy@%0d", ncyc), 32'(busy_b), 32'(active[k]));
        check($sformatf("b.err@%0d", ncyc), 32'(err_b), 32'(err[k]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(0);
    model_step(1);
    ncyc++;
    @(negedge clock);
    compare_models();
  endtask

  // Reset asserted between clock edges: the bus must drop before any clock.
  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check({tag, ".a.xmit_async"}, 32'(xmit_a), 0);
    check({tag, ".b.xmit_async"}, 32'(xmit_b), 0);
    check({tag, ".a.busy_async"}, 32'(busy_a), 0);
    tick();
    reset_n = 1'b1;
  endtask

  logic [2:0] exp28 [6];
  logic [2:0] beh;
  bit         pa;
  int         pu;

  initial begin
    ncyc    = 0;
    reset_n = 1'b0;
    rts     = 3'b000;
    model_reset(0);
    model_reset(1);
    @(negedge clock);
    tick();
    tick();
    check("reset.a.xmit", 32'(xmit_a), 0);
    check("reset.a.gid", 32'(gid_a), 0);
    reset_n = 1'b1;
    tick();

    // Single requester, then wrap-around from rr_ptr=2 with 3'b101.
    rts = 3'b010;
    tick();
    check("single.xmit", 32'(xmit_a), 32'b010);
    check("single.gid", 32'(gid_a), 1);
    tick();
    check("single.release", 32'(xmit_a), 0);
    rts = 3'b101;
    tick();
    check("wrap.first", 32'(xmit_a), 32'b100);
    check("wrap.first_gid", 32'(gid_a), 2);
    tick();
    rts = 3'b001;
    tick();
    check("wrap.second", 32'(xmit_a), 32'b001);
    rts = 3'b000;
    tick();
    tick();

    // All three requesting from a fresh reset: 0,1,2 one every two cycles.
    async_reset("rr");
    exp28 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    rts = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr.seq%0d", i), 32'(xmit_a), 32'(exp28[i]));
      if (i % 2 == 1) rts[i / 2] = 1'b0;
    end
    tick();

    // Long grant aborted by the grantee in its second transmit cycle.
    async_reset("abort");
    rts = 3'b010;
    tick();
    check("abort.grant", 32'(xmit_b), 32'b010);
    tick();
    check("abort.hold", 32'(xmit_b), 32'b010);
    check("abort.noerr", 32'(err_b), 0);
    rts = 3'b000;
    tick();
    check("abort.err", 32'(err_b), 1);
    check("abort.xmit0", 32'(xmit_b), 0);
    rts = 3'b011;
    tick();
    check("abort.err_once", 32'(err_b), 0);
    check("abort.ptr_adv", 32'(xmit_b), 32'b001);
    rts = 3'b000;
    repeat (4) tick();

    // Reset in the middle of a grant, then arbitration restarts at unit 0.
    rts = 3'b100;
    tick();
    check("midrst.granted", 32'(xmit_a), 32'b100);
    async_reset("midrst");
    rts = 3'b110;
    tick();
    check("midrst.first", 32'(xmit_a), 32'b010);
    rts = 3'b000;
    tick();
    tick();

    // Randomized traffic: mostly well-behaved requesters, some protocol noise.
    beh = 3'b000;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0) begin
        async_reset("rnd");
        beh = 3'b000;
      end
      for (int j = 0; j < 3; j++)
        if ($urandom_range(3) == 0) beh[j] = 1'b1;
      rts = ($urandom_range(9) == 0) ? 3'($urandom) : beh;
      pa = active[0];
      pu = gunit[0];
      tick();
      if (pa && !active[0]) beh[pu] = 1'b0;
    end

`ifdef CDB_ARB_STATS_EN
    async_reset("stats");
    rts = 3'b001;
    repeat (140000) tick();
    check("stats.sat0", 32'(gc_a[15:0]), 32'hFFFF);
    check("stats.others", 32'(gc_a[47:16]), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
